binary_bcd_scanner: RTL and testbench
=====================================

# binary_bcd_scanner

Sequential, parametrised binary-to-decimal display engine for the temperature readout path. It accepts a fixed-point binary value with one or more fractional bits and converts the integer part to BCD with an iterative shift-add-3 (double-dabble) sequence under a start/busy/done handshake. It holds the result and time-multiplexes it onto a digit-select bus for the 7-segment driver. It also covers the 'C' unit glyph, the half-degree digit, the "Hi" message mode, leading-zero blanking and overflow saturation.

## Interface
- DATA_W, 8: width of `data`, including fractional bits.
- FRAC_BIT, 1: number of fractional LSBs. Only the MSB of the fraction is displayed: 1 -> digit 5, 0 -> digit 0. Legal range is 1..DATA_W-1.
- DIGITS, 4: number of display positions, minimum 3. Positions 2..DIGITS-1 are integer digits, so there are INT_DIG = DIGITS-2 of them.
- SCAN_DIV, 1000: clocks spent on each display position. Minimum 1.
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a conversion of `data`. Sampled only when busy=0.
- data, input, DATA_W: fixed-point value to convert.
- display_hi, input, 1: selects "Hi" message mode. Combinational select; does not affect the stored value.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse when a conversion completes and the display register updates.
- overflow, output, 1: the last converted integer was ≥ 10^INT_DIG.
- digit_sel, output, max(1,$clog2(DIGITS)): current display position.
- decimal_digit, output, 4: glyph code for the current position. 0-9 are digits, 10 is 'C', 11 is 'H', 12 is 'I', 13 is blank.

## Operation
- State machine has three states: IDLE, SHIFT, LOAD.
  - IDLE: on start=1, latch data, clear the BCD accumulator and set the iteration counter to 0. Next state is SHIFT; busy=1 from the next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, int} left by 1. This runs for exactly N = DATA_W-FRAC_BIT cycles, then the state goes to LOAD.
  - LOAD: compute overflow. Write the display register: all nibbles 9 if overflow, else the BCD nibbles. Store the fraction MSB. Pulse done=1, drop busy to 0 and return to IDLE.
- The BCD accumulator is 4*ceil(N*log10(2)+1) bits wide, internal only. Overflow means any nibble above INT_DIG-1 is nonzero.
- start while busy=1 is ignored and not queued. `data` changes during a conversion have no effect.
- Display register is updated only in LOAD; the displayed value never shows a partial result. Before the first conversion it holds all zeros and overflow=0.
- Scanner runs independently of the converter and never stalls:
  - the prescaler counts 0..SCAN_DIV-1;
  - on terminal count, digit_sel increments and wraps from DIGITS-1 to 0.
- Glyph mapping in normal mode (display_hi=0):
  - pos0 = 10 ('C');
  - pos1 = 5 if the stored fraction bit is 1, else 0;
  - pos2..DIGITS-1 = integer digits, least significant first.
  - Leading-zero blanking: an integer position above pos2 shows 13 if it and every higher integer digit are 0. pos2 always shows its digit. Blanking is not applied when overflow=1.
- Glyph mapping in Hi mode (display_hi=1): pos1 = 12, pos2 = 11, every other position = 13.
- display_hi only changes the glyph mapping. The converter, overflow and the stored value are unaffected.

## Timing
- All outputs are registered. decimal_digit always corresponds to digit_sel in the same cycle.
- Reset values: busy=0, done=0, overflow=0, digit_sel=0, decimal_digit=0, prescaler=0, state=IDLE, display register=0.
  - In the first cycle after reset deasserts, decimal_digit shows the pos0 glyph.
- Latency: start sampled at edge k gives busy=1 at k+1. SHIFT occupies k+1..k+N, LOAD happens at k+N+1, and done=1 / new display / busy=0 are visible after edge k+N+1.
  - With defaults (N=7), done arrives 8 cycles after start.
- Back-to-back: start may be asserted in the cycle done=1, since busy=0 there. That start is accepted.
- Reset mid-conversion: the conversion is aborted, no done pulse, and the display register returns to 0.
- done and a scanner position change in the same cycle: decimal_digit at the new position already uses the new value.

## Test plan
- Defaults, SCAN_DIV=4, data=51 (25.5) plus start:
  - done exactly 8 cycles after start, busy high for 8 cycles;
  - scan sequence 10, 5, 5, 2 with each glyph held 4 cycles;
  - overflow=0.
- data=8 (4.0): scan 10, 0, 4, 13 (leading tens digit blanked). Then data=200 (100.0): scan 10, 0, 9, 9 with overflow=1.
- DATA_W=12, FRAC_BIT=1, DIGITS=6, data=1999 (999.5): scan 10, 5, 9, 9, 9, 13 after 12 cycles; overflow=0.
- display_hi=1 with a stored value 25.5: scan 13, 12, 11, 13. Drop display_hi: scan 10, 5, 5, 2 with no new conversion.
- start pulsed again at cycle 3 of a conversion: ignored, only one done pulse. start asserted in the done cycle: a second conversion is accepted and done follows 8 cycles later.
- reset asserted at cycle 4 of a conversion:
  - no done pulse;
  - all outputs at reset values;
  - after release the scan shows 10, 0, 0, 13.

Source files
------------

// File: rtl/binary_bcd_scanner.sv
// binary_bcd_scanner
// ------------------
// Converts a fixed-point binary temperature reading to decimal for a
// time-multiplexed 7-segment display.
//
// The integer part is converted with an iterative shift-add-3 (double
// dabble) sequence under a start/busy/done handshake. The result is held in
// a display register. A free-running scanner walks digit_sel over every
// display position and presents the matching glyph code.
//
// Glyph codes: 0-9 digits, 10 'C', 11 'H', 12 'I', 13 blank.
// Display layout: pos0 = 'C', pos1 = half-degree digit (0 or 5),
// pos2..DIGITS-1 = integer digits, least significant first.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   start          conversion request, sampled only while idle
//   data           fixed-point input, FRAC_BIT fractional LSBs
//   display_hi     selects the "Hi" message instead of the value
//   busy           conversion in progress
//   done           one-cycle pulse when the display register updates
//   overflow       last integer did not fit in DIGITS-2 decimal digits
//   digit_sel      display position currently driven
//   decimal_digit  glyph code for digit_sel (always in step with it)
module binary_bcd_scanner #(
  parameter int DATA_W   = 8,
  parameter int FRAC_BIT = 1,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  localparam int SEL_W   = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              display_hi,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [SEL_W-1:0]  digit_sel,
  output logic [3:0]        decimal_digit
);

  // Integer bits to convert and the number of integer display digits.
  localparam int N       = DATA_W - FRAC_BIT;
  localparam int INT_DIG = DIGITS - 2;
  // ceil(N*log10(2) + 1) decimal digits, in fixed-point integer arithmetic.
  localparam int BCD_DIG = (N * 30103 + 199999) / 100000;
  // Never narrower than the display, so every displayed nibble exists.
  localparam int ACC_DIG = (BCD_DIG > INT_DIG) ? BCD_DIG : INT_DIG;
  localparam int ACC_W   = 4 * ACC_DIG;
  localparam int DISP_W  = 4 * INT_DIG;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               load;

  logic [N-1:0]       int_sh;
  logic [ACC_W-1:0]   bcd;
  logic [ACC_W-1:0]   bcd_adj;
  logic               frac_lat;
  logic               ovf_now;

  logic [DISP_W-1:0]  disp;
  logic               disp_frac;
  logic [DISP_W-1:0]  disp_nxt;
  logic               frac_nxt;
  logic               ovf_nxt;

  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               tc;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
  // so that it carries correctly into the next decade.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
    r = v;
    for (int i = 0; i < ACC_DIG; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // The value does not fit the display when any decade above the top
  // displayed digit is nonzero.
  function automatic logic ovf_of(input logic [ACC_W-1:0] v);
    logic o;
    o = 1'b0;
    for (int i = INT_DIG; i < ACC_DIG; i++) begin
      if (v[4*i +: 4] != 4'd0) o = 1'b1;
    end
    return o;
  endfunction

  // Glyph for one display position. Integer positions above pos2 blank
  // when they and every higher integer digit are zero; a saturated
  // (overflow) display is never blanked.
  function automatic logic [3:0] glyph(input logic [SEL_W-1:0]  pos,
                                       input logic [DISP_W-1:0] d,
                                       input logic              f,
                                       input logic              o,
                                       input logic              hi);
    logic [3:0] g;
    logic       hz;
    int         p;
    p  = int'(pos);
    g  = 4'd13;
    hz = 1'b1;
    if (hi) begin
      if (p == 1)      g = 4'd12;
      else if (p == 2) g = 4'd11;
    end else if (p == 0) begin
      g = 4'd10;
    end else if (p == 1) begin
      g = f ? 4'd5 : 4'd0;
    end else begin
      for (int i = 0; i < INT_DIG; i++) begin
        if (i == p - 2) begin
          hz = 1'b1;
          for (int j = i; j < INT_DIG; j++) begin
            if (d[4*j +: 4] != 4'd0) hz = 1'b0;
          end
          g = (hz && (i > 0) && !o) ? 4'd13 : d[4*i +: 4];
        end
      end
    end
    return g;
  endfunction

  // ---- converter control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (state == IDLE)       cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(N - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == LOAD);
    load     = (state == LOAD);
  end

  // ---- converter datapath ----
  assign bcd_adj = add3(bcd);
  assign ovf_now = ovf_of(bcd);

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      int_sh   <= data[DATA_W-1:FRAC_BIT];
      frac_lat <= data[FRAC_BIT-1];
      bcd      <= '0;
    end else if (state == SHIFT) begin
      bcd    <= {bcd_adj[ACC_W-2:0], int_sh[N-1]};
      int_sh <= int_sh << 1;
    end
  end

  // ---- display register ----
  // Next values feed the glyph lookup too, so a position change in the
  // done cycle already shows the new result.
  always_comb begin
    disp_nxt = disp;
    frac_nxt = disp_frac;
    ovf_nxt  = overflow;
    if (load) begin
      disp_nxt = ovf_now ? {INT_DIG{4'h9}} : bcd[DISP_W-1:0];
      frac_nxt = frac_lat;
      ovf_nxt  = ovf_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp      <= '0;
      disp_frac <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      disp      <= disp_nxt;
      disp_frac <= frac_nxt;
      overflow  <= ovf_nxt;
    end
  end

  // ---- scanner ----
  always_comb begin
    tc      = (pre == PRE_W'(SCAN_DIV - 1));
    pre_nxt = tc ? '0 : pre + PRE_W'(1);
    sel_nxt = digit_sel;
    if (tc) begin
      sel_nxt = (digit_sel == SEL_W'(DIGITS - 1)) ? '0 : digit_sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre           <= '0;
      digit_sel     <= '0;
      decimal_digit <= 4'd0;
    end else begin
      pre           <= pre_nxt;
      digit_sel     <= sel_nxt;
      decimal_digit <= glyph(sel_nxt, disp_nxt, frac_nxt, ovf_nxt, display_hi);
    end
  end

endmodule

// File: tb/tb_binary_bcd_scanner.sv
// Testbench for binary_bcd_scanner: a default-sized instance (A) and a
// 12-bit / 6-digit instance (B), both scanning every 4 clocks.
`timescale 1ns/1ps
module tb_binary_bcd_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start_a = 1'b0;
  logic [7:0]  data_a = '0;
  logic        hi_a = 1'b0;
  logic        busy_a, done_a, ovf_a;
  logic [1:0]  sel_a;
  logic [3:0]  dd_a;

  logic        start_b = 1'b0;
  logic [11:0] data_b = '0;
  logic        hi_b = 1'b0;
  logic        busy_b, done_b, ovf_b;
  logic [2:0]  sel_b;
  logic [3:0]  dd_b;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  // Reference model of the stored display contents.
  int ma_int = 0, ma_frac = 0;
  bit ma_ovf = 0;
  int mb_int = 0, mb_frac = 0;
  bit mb_ovf = 0;

  binary_bcd_scanner #(.SCAN_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data(data_a),
    .display_hi(hi_a), .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .digit_sel(sel_a), .decimal_digit(dd_a)
  );

  binary_bcd_scanner #(.DATA_W(12), .FRAC_BIT(1), .DIGITS(6), .SCAN_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data(data_b),
    .display_hi(hi_b), .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .digit_sel(sel_b), .decimal_digit(dd_b)
  );

  always #5 clk = ~clk;

  // Clock edges since reset; the scan position is (edges / 4) mod DIGITS.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_glyph(input int pos, input int digits, input int ival,
                                   input int frac, input bit ovf, input bit hi);
    int shown, i;
    if (hi) return (pos == 1) ? 12 : (pos == 2) ? 11 : 13;
    if (pos == 0) return 10;
    if (pos == 1) return frac ? 5 : 0;
    i = pos - 2;
    shown = ovf ? pow10(digits - 2) - 1 : ival;
    if (!ovf && i > 0 && shown < pow10(i)) return 13;
    return (shown / pow10(i)) % 10;
  endfunction

  task automatic set_a(input int v);
    ma_int = v / 2; ma_frac = v % 2; ma_ovf = (ma_int >= 100);
  endtask

  task automatic set_b(input int v);
    mb_int = v / 2; mb_frac = v % 2; mb_ovf = (mb_int >= 10000);
  endtask

  // Starts a conversion on A and watches a fixed window. c counts clock
  // edges after the edge that sampled start. Input data is scrambled while
  // the conversion runs.
  task automatic convert_a(input int v, output int lat, output int dones, output int busy_cyc);
    @(negedge clk); data_a = v[7:0]; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    lat = -1; dones = 0; busy_cyc = 0;
    for (int c = 0; c <= 20; c++) begin
      if (busy_a) busy_cyc++;
      if (done_a) begin dones++; if (lat < 0) lat = c; end
      data_a = 8'($urandom);
      if (c < 20) @(negedge clk);
    end
  endtask

  task automatic convert_b(input int v, output int lat, output int dones, output int busy_cyc);
    @(negedge clk); data_b = v[11:0]; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    lat = -1; dones = 0; busy_cyc = 0;
    for (int c = 0; c <= 24; c++) begin
      if (busy_b) busy_cyc++;
      if (done_b) begin dones++; if (lat < 0) lat = c; end
      data_b = 12'($urandom);
      if (c < 24) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int es, g;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b expected 0", done_a); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %0b expected 0", ovf_a); end
    n_cmp++; if (sel_a !== 2'd0) begin n_bad++; $display("FAIL rst_sel: got %0d expected 0", sel_a); end
    n_cmp++; if (dd_a !== 4'd0) begin n_bad++; $display("FAIL rst_digit: got %0d expected 0", dd_a); end
    n_cmp++; if (dd_b !== 4'd0 || sel_b !== 3'd0) begin n_bad++; $display("FAIL rst_b: got sel %0d digit %0d expected 0 0", sel_b, dd_b); end
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b0);
      n_cmp++; if (sel_a !== 2'(es)) begin n_bad++; $display("FAIL rst_scan_sel: got %0d expected %0d", sel_a, es); end
      n_cmp++; if (dd_a !== 4'(g)) begin n_bad++; $display("FAIL rst_scan_digit: got %0d expected %0d", dd_a, g); end
    end
  endtask

  task automatic test_basic;
    int lat, dn, bc, es, g;
    int seq[4] = '{10, 5, 5, 2};
    convert_a(51, lat, dn, bc);
    set_a(51);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %0b expected 0", ovf_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b0);
      n_cmp++; if (sel_a !== 2'(es)) begin n_bad++; $display("FAIL basic_sel: got %0d expected %0d", sel_a, es); end
      n_cmp++; if (dd_a !== 4'(g) || dd_a !== 4'(seq[es])) begin n_bad++; $display("FAIL basic_digit: got %0d expected %0d", dd_a, seq[es]); end
    end
  endtask

  task automatic test_blank_ovf;
    int lat, dn, bc, es;
    int seq1[4] = '{10, 0, 4, 13};
    int seq2[4] = '{10, 0, 9, 9};
    convert_a(8, lat, dn, bc);
    set_a(8);
    n_cmp++; if (lat !== 8 || dn !== 1) begin n_bad++; $display("FAIL blank_done: got lat %0d count %0d expected 8 1", lat, dn); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL blank_ovf: got %0b expected 0", ovf_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      n_cmp++; if (dd_a !== 4'(seq1[es]) || sel_a !== 2'(es)) begin n_bad++; $display("FAIL blank_digit: got %0d at %0d expected %0d at %0d", dd_a, sel_a, seq1[es], es); end
    end
    convert_a(200, lat, dn, bc);
    set_a(200);
    n_cmp++; if (lat !== 8 || dn !== 1) begin n_bad++; $display("FAIL ovf_done: got lat %0d count %0d expected 8 1", lat, dn); end
    n_cmp++; if (ovf_a !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b expected 1", ovf_a); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      n_cmp++; if (dd_a !== 4'(seq2[es]) || sel_a !== 2'(es)) begin n_bad++; $display("FAIL ovf_digit: got %0d at %0d expected %0d at %0d", dd_a, sel_a, seq2[es], es); end
    end
  endtask

  task automatic test_wide;
    int lat, dn, bc, es, g;
    int seq[6] = '{10, 5, 9, 9, 9, 13};
    convert_b(1999, lat, dn, bc);
    set_b(1999);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL wide_latency: got %0d expected 12", lat); end
    n_cmp++; if (dn !== 1 || bc !== 12) begin n_bad++; $display("FAIL wide_handshake: got done %0d busy %0d expected 1 12", dn, bc); end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL wide_ovf: got %0b expected 0", ovf_b); end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      es = (edges / 4) % 6;
      g = exp_glyph(es, 6, mb_int, mb_frac, mb_ovf, 1'b0);
      n_cmp++; if (sel_b !== 3'(es)) begin n_bad++; $display("FAIL wide_sel: got %0d expected %0d", sel_b, es); end
      n_cmp++; if (dd_b !== 4'(g) || dd_b !== 4'(seq[es])) begin n_bad++; $display("FAIL wide_digit: got %0d expected %0d", dd_b, seq[es]); end
    end
  endtask

  task automatic test_hi;
    int lat, dn, bc, es, g;
    int seq_hi[4] = '{13, 12, 11, 13};
    int seq_n[4]  = '{10, 5, 5, 2};
    convert_a(51, lat, dn, bc);
    set_a(51);
    @(negedge clk); hi_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b1);
      n_cmp++; if (dd_a !== 4'(g) || dd_a !== 4'(seq_hi[es])) begin n_bad++; $display("FAIL hi_digit: got %0d expected %0d", dd_a, seq_hi[es]); end
      n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin n_bad++; $display("FAIL hi_status: got busy %0b done %0b ovf %0b expected 0 0 0", busy_a, done_a, ovf_a); end
    end
    hi_a = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      n_cmp++; if (dd_a !== 4'(seq_n[es])) begin n_bad++; $display("FAIL hi_release_digit: got %0d expected %0d", dd_a, seq_n[es]); end
    end
  endtask

  task automatic test_back_to_back;
    int first, second, ndone, es, g;
    first = -1; second = -1; ndone = 0;
    @(negedge clk); data_a = 8'd51; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t == 3) begin start_a = 1'b1; data_a = 8'd200; end
      else if (t == 4) start_a = 1'b0;
      if (first >= 0 && t == first + 1) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        if (first < 0) begin first = t; start_a = 1'b1; data_a = 8'd16; end
        else if (second < 0) second = t;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    set_a(16);
    n_cmp++; if (first !== 8) begin n_bad++; $display("FAIL b2b_first_done: got %0d expected 8", first); end
    n_cmp++; if (second !== 17) begin n_bad++; $display("FAIL b2b_second_done: got %0d expected 17", second); end
    n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      es = (edges / 4) % 4;
      g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b0);
      n_cmp++; if (dd_a !== 4'(g)) begin n_bad++; $display("FAIL b2b_digit: got %0d expected %0d", dd_a, g); end
    end
  endtask

  task automatic test_random;
    int va, vb, lat, dn, bc, es, g;
    for (int it = 0; it < 8; it++) begin
      va = $urandom_range(0, 255);
      convert_a(va, lat, dn, bc);
      set_a(va);
      n_cmp++; if (lat !== 8 || dn !== 1) begin n_bad++; $display("FAIL rnd_a_done: data %0d got lat %0d count %0d expected 8 1", va, lat, dn); end
      n_cmp++; if (ovf_a !== ma_ovf) begin n_bad++; $display("FAIL rnd_a_ovf: data %0d got %0b expected %0b", va, ovf_a, ma_ovf); end
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        es = (edges / 4) % 4;
        g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b0);
        n_cmp++; if (dd_a !== 4'(g)) begin n_bad++; $display("FAIL rnd_a_digit: data %0d pos %0d got %0d expected %0d", va, es, dd_a, g); end
      end
      vb = $urandom_range(0, 4095);
      convert_b(vb, lat, dn, bc);
      set_b(vb);
      n_cmp++; if (lat !== 12 || dn !== 1) begin n_bad++; $display("FAIL rnd_b_done: data %0d got lat %0d count %0d expected 12 1", vb, lat, dn); end
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        es = (edges / 4) % 6;
        g = exp_glyph(es, 6, mb_int, mb_frac, mb_ovf, 1'b0);
        n_cmp++; if (dd_b !== 4'(g)) begin n_bad++; $display("FAIL rnd_b_digit: data %0d pos %0d got %0d expected %0d", vb, es, dd_b, g); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, dn, bc, es, g;
    int seq[4] = '{10, 0, 0, 13};
    convert_a(200, lat, dn, bc);
    set_a(200);
    @(negedge clk); data_a = 8'd51; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_handshake: got busy %0b done %0b expected 0 0", busy_a, done_a); end
    n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovf: got %0b expected 0", ovf_a); end
    n_cmp++; if (sel_a !== 2'd0 || dd_a !== 4'd0) begin n_bad++; $display("FAIL mid_rst_scan: got sel %0d digit %0d expected 0 0", sel_a, dd_a); end
    @(negedge clk);
    reset = 1'b0;
    set_a(0); set_b(0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a) dn++;
      es = (edges / 4) % 4;
      g = exp_glyph(es, 4, ma_int, ma_frac, ma_ovf, 1'b0);
      n_cmp++; if (dd_a !== 4'(g) || dd_a !== 4'(seq[es])) begin n_bad++; $display("FAIL mid_scan_digit: got %0d expected %0d", dd_a, seq[es]); end
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d pulses expected 0", dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank_ovf();
    test_wide();
    test_hi();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
